exc_pipeline_controller: RTL and testbench

EXC_PIPELINE_CONTROLLER -- requirements
Module: exc_pipeline_controller

---
 rtl/exc_pipeline_controller_if.sv | 27 ++
 rtl/exc_pipeline_controller.sv | 109 ++++++++++
 tb/tb_exc_pipeline_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/exc_pipeline_controller_if.sv
// Pipeline-to-exception-controller bundle: M/D-stage requests in, stage enables/clears and exception state out.
// master = pipeline datapath side, slave = exception controller.
interface exc_pipeline_controller_if;
  logic        exc_M;
  logic [4:0]  exc_code_M;
  logic [31:0] PC_M;
  logic        mem_busy;
  logic        eret_D;
  logic        EN_F, EN_D, EN_E, EN_M, EN_W;
  logic        CLR_D, CLR_E, CLR_M, CLR_W;
  logic [1:0]  PC_sel;
  logic [31:0] EPC;
  logic [4:0]  Cause;
  logic        exc_active;

  modport master (
    output exc_M, exc_code_M, PC_M, mem_busy, eret_D,
    input  EN_F, EN_D, EN_E, EN_M, EN_W, CLR_D, CLR_E, CLR_M, CLR_W,
    input  PC_sel, EPC, Cause, exc_active
  );

  modport slave (
    input  exc_M, exc_code_M, PC_M, mem_busy, eret_D,
    output EN_F, EN_D, EN_E, EN_M, EN_W, CLR_D, CLR_E, CLR_M, CLR_W,
    output PC_sel, EPC, Cause, exc_active
  );
endinterface

// File: rtl/exc_pipeline_controller.sv
// Exception/ERET sequencer for a 5-stage pipeline: drains a busy memory access, flushes, redirects PC.
// Latency: enables/clears are combinational from state; EPC/Cause/exc_active update on the capturing edge.
// Backpressure: mem_busy stalls F..M and bubbles W; a stall of STALL_LIMIT cycles raises a bus-timeout exception.
module exc_pipeline_controller #(
  parameter logic [7:0] STALL_LIMIT  = 8'd255,
  parameter logic [4:0] TIMEOUT_CODE = 5'd7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  exc_pipeline_controller_if.slave  bus
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] ERET  = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [7:0]  stall_cnt, stall_cnt_nxt, stall_cnt_inc;
  logic [31:0] epc_q;
  logic [4:0]  cause_q;
  logic        exc_active_q;
  logic        timeout, take_exc, stall;
  logic [4:0]  en;
  logic [3:0]  clr;
  logic [1:0]  pc_sel;

  assign stall         = bus.mem_busy;
  assign timeout       = bus.mem_busy && (stall_cnt == STALL_LIMIT);
  assign take_exc      = (state == RUN) && (bus.exc_M || timeout) && !exc_active_q;
  assign stall_cnt_inc = (stall_cnt == STALL_LIMIT) ? stall_cnt : stall_cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (take_exc && timeout && !bus.exc_M) state_nxt = FLUSH;
        else if (take_exc && bus.mem_busy)     state_nxt = DRAIN;
        else if (take_exc)                     state_nxt = FLUSH;
        else if (bus.eret_D && !stall)         state_nxt = ERET;
      end
      DRAIN:   if (!bus.mem_busy || timeout) state_nxt = FLUSH;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_nxt = bus.mem_busy ? stall_cnt : 8'd0;
    case (state)
      RUN:   stall_cnt_nxt = bus.mem_busy ? stall_cnt_inc : 8'd0;
      DRAIN: stall_cnt_nxt = (state_nxt != DRAIN || !bus.mem_busy) ? 8'd0 : stall_cnt_inc;
      default: ;
    endcase
  end

  // Outputs fall back to free-running values whenever reset is asserted, independent of clk.
  always_comb begin
    en     = 5'b11111;
    clr    = 4'b0000;
    pc_sel = 2'b00;
    if (rst_n) begin
      case (state)
        RUN: begin
          en  = {{4{!stall}}, 1'b1};
          clr = {3'b000, stall};
        end
        DRAIN: begin
          en  = 5'b00001;
          clr = 4'b0001;
        end
        FLUSH: begin
          clr    = 4'b1111;
          pc_sel = 2'b01;
        end
        default: begin
          clr    = 4'b1000;
          pc_sel = 2'b10;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      stall_cnt    <= 8'd0;
      epc_q        <= 32'd0;
      cause_q      <= 5'd0;
      exc_active_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      if (take_exc) begin
        epc_q   <= bus.PC_M;
        cause_q <= bus.exc_M ? bus.exc_code_M : TIMEOUT_CODE;
      end
      if (state_nxt == FLUSH && state != FLUSH) exc_active_q <= 1'b1;
      else if (state_nxt == ERET)               exc_active_q <= 1'b0;
    end
  end

  assign {bus.EN_F, bus.EN_D, bus.EN_E, bus.EN_M, bus.EN_W} = en;
  assign {bus.CLR_D, bus.CLR_E, bus.CLR_M, bus.CLR_W}       = clr;
  assign bus.PC_sel     = pc_sel;
  assign bus.EPC        = epc_q;
  assign bus.Cause      = cause_q;
  assign bus.exc_active = exc_active_q;

endmodule

// File: tb/tb_exc_pipeline_controller.sv
// Directed scenarios then random traffic against a sequence-level reference model of the exception controller.
module tb_exc_pipeline_controller;

  localparam int LIMIT = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_FLUSH = 2, M_ERET = 3;

  logic clk;
  logic rst_n;
  exc_pipeline_controller_if bus();

  exc_pipeline_controller #(.STALL_LIMIT(8'd4), .TIMEOUT_CODE(5'd7)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          m_mode;
  int          m_cnt;
  logic [31:0] m_epc;
  logic [4:0]  m_cause;
  logic        m_active;

  function automatic logic [48:0] model_out(input logic busy);
    logic [4:0] en;
    logic [3:0] clr;
    logic [1:0] sel;
    en  = 5'b11111;
    clr = 4'b0000;
    sel = 2'b00;
    if (rst_n) begin
      if (m_mode == M_RUN && busy) begin
        en  = 5'b00001;
        clr = 4'b0001;
      end else if (m_mode == M_DRAIN) begin
        en  = 5'b00001;
        clr = 4'b0001;
      end else if (m_mode == M_FLUSH) begin
        clr = 4'b1111;
        sel = 2'b01;
      end else if (m_mode == M_ERET) begin
        clr = 4'b1000;
        sel = 2'b10;
      end
    end
    return {en, clr, sel, m_active, m_cause, m_epc};
  endfunction

  task automatic model_reset();
    m_mode   = M_RUN;
    m_cnt    = 0;
    m_epc    = 32'd0;
    m_cause  = 5'd0;
    m_active = 1'b0;
  endtask

  task automatic model_clock(input logic exc, input logic [4:0] code, input logic [31:0] pc,
                             input logic busy, input logic eret);
    bit tmo;
    int nxt;
    int cnt_nxt;
    tmo     = busy && (m_cnt == LIMIT);
    nxt     = M_RUN;
    cnt_nxt = busy ? m_cnt : 0;
    if (m_mode == M_RUN) begin
      cnt_nxt = busy ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
      if ((exc || tmo) && !m_active) begin
        m_epc   = pc;
        m_cause = exc ? code : 5'd7;
        nxt     = (exc && busy) ? M_DRAIN : M_FLUSH;
      end else if (eret && !busy) begin
        nxt = M_ERET;
      end
    end else if (m_mode == M_DRAIN) begin
      if (!busy || tmo) begin
        nxt     = M_FLUSH;
        cnt_nxt = 0;
      end else begin
        nxt     = M_DRAIN;
        cnt_nxt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
      end
    end
    if (nxt == M_FLUSH) m_active = 1'b1;
    if (nxt == M_ERET)  m_active = 1'b0;
    m_mode = nxt;
    m_cnt  = cnt_nxt;
  endtask

  task automatic check(input string tag);
    logic [48:0] obs, exp;
    obs = {bus.EN_F, bus.EN_D, bus.EN_E, bus.EN_M, bus.EN_W,
           bus.CLR_D, bus.CLR_E, bus.CLR_M, bus.CLR_W,
           bus.PC_sel, bus.exc_active, bus.Cause, bus.EPC};
    exp = model_out(bus.mem_busy);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic exc, input logic [4:0] code, input logic [31:0] pc,
                      input logic busy, input logic eret, input string tag);
    @(negedge clk);
    bus.exc_M      = exc;
    bus.exc_code_M = code;
    bus.PC_M       = pc;
    bus.mem_busy   = busy;
    bus.eret_D     = eret;
    #1;
    check(tag);
    @(posedge clk);
    model_clock(exc, code, pc, busy, eret);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, tag);
  endtask

  // Release on a falling edge with quiet inputs so the first rising edge afterwards is modelled.
  task automatic release_reset();
    @(negedge clk);
    bus.exc_M    = 1'b0;
    bus.mem_busy = 1'b0;
    bus.eret_D   = 1'b0;
    #1;
    check("reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    model_clock(1'b0, bus.exc_code_M, bus.PC_M, 1'b0, 1'b0);
  endtask

  initial begin
    logic busy_r;
    rst_n          = 1'b0;
    bus.exc_M      = 1'b0;
    bus.exc_code_M = 5'd0;
    bus.PC_M       = 32'd0;
    bus.mem_busy   = 1'b1;
    bus.eret_D     = 1'b0;
    model_reset();
    #3;
    check("reset_init");
    release_reset();

    // Plain exception with idle memory
    step(1'b1, 5'd4, 32'h0040_0010, 1'b0, 1'b0, "exc_take");
    idle("exc_flush");
    idle("exc_back_run");

    // Nested exception ignored, then ERET
    step(1'b1, 5'd9, 32'h0000_BEEF, 1'b0, 1'b0, "exc_ignored");
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, "eret_req");
    idle("eret_cycle");
    idle("eret_back_run");

    // Exception behind a 3-cycle memory access
    step(1'b1, 5'd12, 32'h0000_1000, 1'b1, 1'b0, "drain_take");
    step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "drain_1");
    step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "drain_2");
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, "drain_3");
    idle("drain_flush");
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, "drain_eret");
    idle("drain_eret_cycle");

    // Exception and ERET in the same cycle
    step(1'b1, 5'd3, 32'h0000_2220, 1'b0, 1'b1, "both_take");
    idle("both_flush");
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, "both_eret");
    idle("both_eret_cycle");

    // Bus timeout after STALL_LIMIT+1 stalled cycles; ERET held off while stalled
    for (int i = 0; i < 5; i++)
      step(1'b0, 5'd1, 32'h0000_3000 + 32'(i * 4), 1'b1, 1'b1, "timeout_stall");
    idle("timeout_flush");
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, "timeout_eret");
    idle("timeout_eret_cycle");

    // Asynchronous reset mid-DRAIN, away from the clock edge
    step(1'b1, 5'd5, 32'h0000_4444, 1'b1, 1'b0, "rst_drain_take");
    step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "rst_drain_1");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_mid_drain");
    release_reset();
    idle("after_reset");

    // Random traffic with bursty memory stalls
    busy_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) busy_r = ~busy_r;
      step(($urandom_range(0, 7) == 0), 5'($urandom), $urandom, busy_r,
           ($urandom_range(0, 4) == 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
